// File: rtl/toggle_frame_decoder_pkg.sv
// toggle_frame_decoder_pkg: state encoding and frame constants shared by the decoder
package toggle_frame_decoder_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;
  localparam logic [7:0] HEADER    = 8'h54;
  localparam logic [3:0] FRAME_LEN = 4'd8;
endpackage

// File: rtl/toggle_frame_decoder_strobe_timer.sv
// strobe_timer: loadable down-counter that flags the last cycle of a timed phase
// ports: clk, rst, load (take count), count (phase length in cycles), done (final cycle of phase)
module strobe_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] count,
  output logic       done
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= count;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  assign done = cnt == 8'd1;
endmodule

// File: rtl/toggle_frame_decoder.sv
// toggle_frame_decoder: turns 'T'-headed 8-byte frames into a timed toggle strobe plus 64-bit mask
// ports: clk, rst, in_data/in_valid/in_ready (byte stream), toggle_mask/toggle_enable (pin controller),
//        busy (not idle), timeout_err (partial frame dropped; only with TOGGLE_FRAME_TIMEOUT_EN)
module toggle_frame_decoder
  import toggle_frame_decoder_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] toggle_mask,
  output logic        toggle_enable,
  output logic        busy,
  output logic        timeout_err
);
  logic [1:0]  state;
  logic [63:0] staging;
  logic [3:0]  byte_cnt;
  logic        accept, last, done, tmo;
  // outputs are gated by rst so they read inactive during the reset cycle itself
  assign in_ready      = !rst && (state == S_IDLE || state == S_LOAD);
  assign busy          = !rst && state != S_IDLE;
  assign toggle_enable = !rst && state == S_PULSE;
  assign accept        = in_valid && in_ready;
  assign last          = accept && state == S_LOAD && byte_cnt == FRAME_LEN - 4'd1;
  strobe_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (last || (state == S_PULSE && done)),
    .count (last ? 8'(PULSE_CYCLES) : 8'(GAP_CYCLES)),
    .done  (done)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state       <= S_IDLE;
      staging     <= '0;
      byte_cnt    <= '0;
      toggle_mask <= '0;
    end else
      case (state)
        S_IDLE: if (accept && in_data == HEADER) begin
          state    <= S_LOAD;
          byte_cnt <= '0;
        end
        S_LOAD: if (accept) begin
          staging  <= {staging[55:0], in_data};
          byte_cnt <= byte_cnt + 4'd1;
          if (last) begin
            state       <= S_PULSE;
            toggle_mask <= {staging[55:0], in_data};
          end
        end else if (tmo) begin
          state   <= S_IDLE;
          staging <= '0;
        end
        S_PULSE: if (done) state <= S_GAP;
        default: if (done) state <= S_IDLE;
      endcase
`ifdef TOGGLE_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  // idle_cnt holds the number of byte-less LOAD cycles already elapsed
  assign tmo = state == S_LOAD && !accept && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    idle_cnt    <= (rst || state != S_LOAD || accept || tmo) ? '0 : idle_cnt + TW'(1);
    timeout_err <= !rst && tmo;
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: doc/toggle_frame_decoder.md
TOGGLE_FRAME_DECODER -- requirements
Module: toggle_frame_decoder

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 2: cycles toggle_enable is held high per command, legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: minimum cycles toggle_enable is held low after a pulse, legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between bytes inside one frame.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, 8 bits: byte from the upstream receiver.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: decoder accepts a byte this cycle.
REQ-009 SHALL have port toggle_mask, output, 64 bits: mask to the pin controller.
REQ-010 SHALL have port toggle_enable, output, 1 bit: toggle strobe to the pin controller.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a partial frame is discarded.

Function
REQ-013 SHALL transfer a byte only on a cycle where in_valid and in_ready are both high.
REQ-014 SHALL implement states IDLE, LOAD, PULSE and GAP.
REQ-015 IDLE: in_ready=1; byte 0x54 ('T') -> LOAD with byte counter=0; any other byte is consumed and dropped.
REQ-016 LOAD: in_ready=1; each byte shifts into a 64-bit staging register MSB-first (first byte -> bits 63:56); after the 8th byte -> PULSE.
REQ-017 Entering PULSE: toggle_mask SHALL load the staging register and toggle_enable SHALL rise on the same clock edge.
REQ-018 PULSE: in_ready=0; toggle_enable=1 for exactly PULSE_CYCLES cycles, then -> GAP.
REQ-019 GAP: in_ready=0; toggle_enable=0 for exactly GAP_CYCLES cycles, then -> IDLE.
REQ-020 toggle_mask SHALL change only at PULSE entry; it holds its value through GAP, IDLE and LOAD.
REQ-021 A 0x54 byte received in LOAD SHALL be treated as mask data, not as a new header.
REQ-022 Latency: toggle_enable SHALL rise on the clock edge that accepts the 8th mask byte.
REQ-023 Back-to-back frames: enable-to-enable spacing SHALL be at least PULSE_CYCLES+GAP_CYCLES+9 cycles.
REQ-024 Cycle counters SHALL be 8 bits wide; the timeout counter SHALL be sized as $clog2(TIMEOUT_CYCLES+1) bits.

Reset
REQ-025 While rst=1: state=IDLE, toggle_mask=0, toggle_enable=0, in_ready=0, busy=0, timeout_err=0, and staging and counters are cleared.
REQ-026 Reset asserted mid-LOAD or mid-PULSE SHALL abort the frame with no further toggle_enable pulse; in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-027 With TOGGLE_FRAME_TIMEOUT_EN defined: in LOAD, if TIMEOUT_CYCLES consecutive cycles pass with no accepted byte, the decoder SHALL discard the staging register, return to IDLE and pulse timeout_err for one cycle; toggle_mask SHALL be unchanged.
REQ-028 Without TOGGLE_FRAME_TIMEOUT_EN: the decoder SHALL wait in LOAD indefinitely, timeout_err SHALL be tied to 0, and no timeout counter logic SHALL be present.

Structure
REQ-029 A shared package SHALL hold the state encoding, the header constant 0x54 and the frame length constant 8.
REQ-030 The cycle counting for PULSE and GAP SHALL be done in one sub-module, strobe_timer, which is loaded with a count and asserts done when the count expires.

Verification
REQ-031 Frame 54 01 00 00 00 00 00 00 80 -> toggle_mask=0x0100000000000080; toggle_enable high for 2 cycles, then low for 2 cycles; busy falls afterwards.
REQ-032 Bytes 41 FF 54 then 8×FF -> 41 and FF are dropped; mask=0xFFFFFFFFFFFFFFFF; exactly one enable pulse.
REQ-033 in_valid held high continuously with two full frames -> in_ready=0 for 4 cycles between frames; two separate enable pulses; both masks applied in order.
REQ-034 rst asserted for 1 cycle after the 4th mask byte -> no enable pulse and toggle_mask=0; a following complete frame is decoded normally.
REQ-035 With TOGGLE_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16: 54 AA then 16 idle cycles -> timeout_err pulses once, state=IDLE, toggle_mask unchanged, and the next 0x54 starts a new frame.
REQ-036 Connected to a pin controller, the frame 54 00..00 01 sent twice -> output pin 0 goes 0->1->0.
